// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// default geometry, the controller state encoding and the tag-width helper.
// Optional build macro used by the controller: CACHE_STATS_EN.
package cache_pkg;

  // Default geometry: 12-bit word address, 32-bit data, 16 one-word lines.
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 32;
  localparam int INDEX_W_DEF = 4;

  // Tag width derived from the geometry above.
  localparam int TAG_W_DEF   = ADDR_W_DEF - INDEX_W_DEF;

  // Controller states. The encoding is explicit so that the debug port
  // carries stable values across builds.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  // Tag width for an arbitrary address/index split.
  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - index_w;
  endfunction

endpackage

// File: rtl/cache_array.sv
// Line storage for the direct-mapped cache: one valid bit, one tag and one
// data word per line. Reads are combinational by index; writes land on the
// rising clock edge. Valid bits clear asynchronously on reset, while tag and
// data contents are left as they are (they are never used while invalid).
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Valid bits: cleared by reset, set by any line write (fill or store hit).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage: plain synchronous write, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  // Combinational read port addressed by the latched request index.
  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_q[rd_index];
    rd_data  = data_q[rd_index];
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate cache
// controller sitting between a CPU data port and main memory.
//
// Handshake: the CPU holds cpu_r_en / cpu_w_en (with address and data)
// until cpu_ready pulses for one cycle; the request is captured in IDLE and
// the latched copy is used for the rest of the transaction, so input
// changes while stall=1 have no effect. Memory: mem_req (with mem_we,
// mem_addr, mem_wdata) is held until a one-cycle mem_ack; ack seen in any
// other state is ignored.
//
// Optional build macro: CACHE_STATS_EN adds saturating hit_cnt / miss_cnt
// outputs counting lookups; timing is the same with or without it.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_r_en,
  input  logic              cpu_w_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        state_dbg
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_W);

  state_e state;
  state_e state_nx;

  // Latched request: address, store data and operation (1 = store).
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_store;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               hit;

  logic               arr_we;
  logic [DATA_W-1:0]  arr_wdata;

  logic               new_req;

  assign req_index = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign new_req   = cpu_r_en | cpu_w_en;
  assign state_dbg = state;

  cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (arr_we),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_data  (arr_wdata)
  );

  // Hit detection on the latched address; only meaningful in LOOKUP.
  always_comb begin
    hit = rd_valid && (rd_tag == req_tag);
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (new_req) state_nx = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        // Stores always go through to memory; loads only on a miss.
        if (req_store)  state_nx = ST_MEM_WRITE;
        else if (hit)   state_nx = ST_RESP;
        else            state_nx = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        if (mem_ack) state_nx = ST_RESP;
      end
      ST_MEM_WRITE: begin
        if (mem_ack) state_nx = ST_RESP;
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Line writes: store hit updates the data in place (tag unchanged), a
  // load miss fills from memory on ack. A store miss never touches the
  // array, and a fill simply overwrites whatever line shared the index.
  always_comb begin
    arr_we    = 1'b0;
    arr_wdata = req_wdata;
    if (state == ST_LOOKUP && req_store && hit) begin
      arr_we    = 1'b1;
      arr_wdata = req_wdata;
    end else if (state == ST_MEM_READ && mem_ack) begin
      arr_we    = 1'b1;
      arr_wdata = mem_rdata;
    end
  end

  // State register and registered outputs. Handshake outputs are derived
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      stall     <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_store <= 1'b0;
    end else begin
      state     <= state_nx;
      stall     <= (state_nx != ST_IDLE);
      cpu_ready <= (state_nx == ST_RESP);
      mem_req   <= (state_nx == ST_MEM_READ) || (state_nx == ST_MEM_WRITE);
      mem_we    <= (state_nx == ST_MEM_WRITE);

      // Capture the request only in IDLE; store wins when both enables are set.
      if (state == ST_IDLE && new_req) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_store <= cpu_w_en;
      end

      if (state == ST_LOOKUP) begin
        if (req_store) begin
          mem_addr  <= req_addr;
          mem_wdata <= req_wdata;
        end else if (hit) begin
          cpu_rdata <= rd_data;
        end else begin
          mem_addr  <= req_addr;
        end
      end

      if (state == ST_MEM_READ && mem_ack) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating lookup statistics; every LOOKUP cycle counts exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == ST_LOOKUP) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus a
// randomized run, all checked against a line-level cache model and a
// reference memory image kept in the bench.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int WORDS   = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              cpu_r_en;
  logic              cpu_w_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [2:0]        state_dbg;

  int checks;
  int errors;

  // Reference model: line contents plus the memory image the cache fronts.
  logic              m_valid [LINES];
  logic [TAG_W-1:0]  m_tag   [LINES];
  logic [DATA_W-1:0] m_data  [LINES];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] dut_mem [WORDS];
  logic [DATA_W-1:0] exp_q[$];

  // Memory responder bookkeeping.
  bit                auto_mem;
  int                ack_delay;
  int                mem_reads;
  int                mem_writes;
  logic [ADDR_W-1:0] last_addr;
  logic              last_we;
  logic [DATA_W-1:0] last_wdata;

  cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_r_en  (cpu_r_en),
    .cpu_w_en  (cpu_w_en),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory responder ----------------
  // Sees a request at a falling edge, waits ack_delay falling edges, then
  // serves it with a one-cycle ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req && rst) begin
        repeat (ack_delay) @(negedge clk);
        if (mem_req && rst) begin
          last_addr  = mem_addr;
          last_we    = mem_we;
          last_wdata = mem_wdata;
          if (mem_we) begin
            dut_mem[mem_addr] = mem_wdata;
            mem_writes++;
          end else begin
            mem_rdata = dut_mem[mem_addr];
            mem_reads++;
          end
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Write-through, no-write-allocate, direct-mapped one-word lines.
  task automatic model_access(input bit is_store, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, output bit hit,
                              output logic [DATA_W-1:0] rd);
    int idx;
    logic [TAG_W-1:0] tg;
    idx = int'(a) % LINES;
    tg  = TAG_W'(int'(a) / LINES);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    rd  = '0;
    if (is_store) begin
      ref_mem[a] = d;
      if (hit) m_data[idx] = d;
    end else begin
      if (!hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = ref_mem[a];
      end
      rd = m_data[idx];
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Issues one CPU request and holds it until cpu_ready; lat counts rising
  // edges from the request to the cycle in which cpu_ready is seen.
  task automatic do_access(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit scramble,
                           output logic [DATA_W-1:0] rdata, output int lat,
                           output bit saw_req, output bit stall_seen,
                           output bit timeout);
    rdata      = '0;
    lat        = 0;
    saw_req    = 1'b0;
    stall_seen = 1'b0;
    timeout    = 1'b1;
    @(negedge clk);
    cpu_r_en  = r;
    cpu_w_en  = w;
    cpu_addr  = a;
    cpu_wdata = d;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) stall_seen = stall;
      if (mem_req) saw_req = 1'b1;
      if (cpu_ready) begin
        rdata   = cpu_rdata;
        timeout = 1'b0;
        break;
      end
      if (scramble) begin
        cpu_addr  = ADDR_W'($urandom);
        cpu_wdata = $urandom;
      end
    end
    cpu_r_en = 1'b0;
    cpu_w_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({cpu_ready, stall, mem_req, mem_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0000", {cpu_ready, stall, mem_req, mem_we});
    end
    checks++;
    if ({cpu_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data rdata=%h addr=%h wdata=%h want all 0", cpu_rdata, mem_addr, mem_wdata);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d want=%0d", state_dbg, ST_IDLE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_miss();
    logic [DATA_W-1:0] rd, exp;
    int lat, r0;
    bit hit, sreq, sst, to;
    dut_mem[12'h010] = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    ack_delay = 3;
    model_access(1'b0, 12'h010, '0, hit, exp);
    r0 = mem_reads;
    do_access(1'b1, 1'b0, 12'h010, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL miss_timeout no cpu_ready within budget"); end
    checks++;
    if (rd !== 32'hDEADBEEF || rd !== exp) begin
      errors++; $display("FAIL miss_data got=%h want=%h", rd, 32'hDEADBEEF);
    end
    checks++;
    if (mem_reads - r0 !== 1) begin errors++; $display("FAIL miss_reads got=%0d want=1", mem_reads - r0); end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL miss_latency got=%0d want=6", lat); end
    checks++;
    if (last_addr !== 12'h010 || last_we !== 1'b0) begin
      errors++; $display("FAIL miss_memreq addr=%h we=%b want addr=010 we=0", last_addr, last_we);
    end
    checks++;
    if (sst !== 1'b1) begin errors++; $display("FAIL miss_stall got=%b want=1", sst); end
  endtask

  task automatic test_read_hit();
    logic [DATA_W-1:0] rd, exp;
    int lat;
    bit hit, sreq, sst, to;
    model_access(1'b0, 12'h010, '0, hit, exp);
    do_access(1'b1, 1'b0, 12'h010, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (sreq !== 1'b0 || to !== 1'b0) begin
      errors++; $display("FAIL hit_noreq saw_req=%b timeout=%b want 0 0", sreq, to);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL hit_latency got=%0d want=2", lat); end
    checks++;
    if (rd !== exp || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL hit_data got=%h want=%h", rd, 32'hDEADBEEF);
    end
  endtask

  task automatic test_store_load();
    logic [DATA_W-1:0] rd, exp;
    int lat, w0;
    bit hit, sreq, sst, to;
    ack_delay = 2;
    model_access(1'b1, 12'h010, 32'h12345678, hit, exp);
    w0 = mem_writes;
    do_access(1'b0, 1'b1, 12'h010, 32'h12345678, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (mem_writes - w0 !== 1 || last_we !== 1'b1) begin
      errors++; $display("FAIL store_write writes=%0d we=%b want 1 1", mem_writes - w0, last_we);
    end
    checks++;
    if (last_addr !== 12'h010 || last_wdata !== 32'h12345678) begin
      errors++; $display("FAIL store_payload addr=%h data=%h want 010 12345678", last_addr, last_wdata);
    end
    checks++;
    if (lat !== 3 + 2) begin errors++; $display("FAIL store_latency got=%0d want=5", lat); end
    model_access(1'b0, 12'h010, '0, hit, exp);
    do_access(1'b1, 1'b0, 12'h010, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (sreq !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL store_then_hit saw_req=%b lat=%0d want 0 2", sreq, lat);
    end
    checks++;
    if (rd !== exp || rd !== 32'h12345678) begin
      errors++; $display("FAIL store_then_data got=%h want=%h", rd, 32'h12345678);
    end
  endtask

  task automatic test_index_conflict();
    logic [DATA_W-1:0] rd, exp;
    int lat, r0;
    bit hit, sreq, sst, to;
    dut_mem[12'h110] = 32'hCAFE0110;
    ref_mem[12'h110] = 32'hCAFE0110;
    ack_delay = 1;
    model_access(1'b0, 12'h110, '0, hit, exp);
    r0 = mem_reads;
    do_access(1'b1, 1'b0, 12'h110, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (mem_reads - r0 !== 1 || rd !== exp) begin
      errors++; $display("FAIL conflict_first reads=%0d data=%h want 1 %h", mem_reads - r0, rd, exp);
    end
    model_access(1'b0, 12'h010, '0, hit, exp);
    r0 = mem_reads;
    do_access(1'b1, 1'b0, 12'h010, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (mem_reads - r0 !== 1 || rd !== 32'h12345678) begin
      errors++; $display("FAIL conflict_second reads=%0d data=%h want 1 12345678", mem_reads - r0, rd);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [DATA_W-1:0] rd, exp;
    int lat, r0, bad;
    bit hit, sreq, sst, to, got_req;
    // 0x010 is cached, so a load of 0x110 misses and reaches MEM_READ.
    auto_mem = 1'b0;
    got_req  = 1'b0;
    @(negedge clk);
    cpu_r_en = 1'b1;
    cpu_addr = 12'h110;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin got_req = 1'b1; break; end
    end
    checks++;
    if (got_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req mem_req never rose"); end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, cpu_ready, stall} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_drop req/ready/stall=%b want 000", {mem_req, cpu_ready, stall});
    end
    cpu_r_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (cpu_ready || stall || mem_req) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_late_ack activity cycles=%0d want=0", bad); end
    model_flush();
    auto_mem  = 1'b1;
    ack_delay = 2;
    model_access(1'b0, 12'h010, '0, hit, exp);
    r0 = mem_reads;
    do_access(1'b1, 1'b0, 12'h010, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (sreq !== 1'b1 || mem_reads - r0 !== 1 || rd !== exp) begin
      errors++; $display("FAIL rst_then_miss saw_req=%b reads=%0d data=%h want 1 1 %h", sreq, mem_reads - r0, rd, exp);
    end
  endtask

  task automatic test_write_priority();
    logic [DATA_W-1:0] rd, exp, d;
    int lat, r0, w0;
    bit hit, sreq, sst, to;
    d = $urandom;
    model_access(1'b1, 12'h020, d, hit, exp);
    r0 = mem_reads;
    w0 = mem_writes;
    do_access(1'b1, 1'b1, 12'h020, d, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (mem_writes - w0 !== 1 || mem_reads - r0 !== 0 || last_we !== 1'b1) begin
      errors++; $display("FAIL both_en_store writes=%0d reads=%0d we=%b want 1 0 1", mem_writes - w0, mem_reads - r0, last_we);
    end
    checks++;
    if (last_addr !== 12'h020 || dut_mem[12'h020] !== d) begin
      errors++; $display("FAIL both_en_payload addr=%h mem=%h want 020 %h", last_addr, dut_mem[12'h020], d);
    end
    // No write-allocate: the following load must still go to memory.
    model_access(1'b0, 12'h020, '0, hit, exp);
    r0 = mem_reads;
    do_access(1'b1, 1'b0, 12'h020, '0, 1'b0, rd, lat, sreq, sst, to);
    checks++;
    if (mem_reads - r0 !== 1 || rd !== d) begin
      errors++; $display("FAIL store_no_alloc reads=%0d data=%h want 1 %h", mem_reads - r0, rd, d);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] rd, exp, d, want;
    logic [ADDR_W-1:0] a;
    int lat, r0, w0, sel, want_lat;
    bit hit, sreq, sst, to, r, w;
    for (int n = 0; n < 80; n++) begin
      ack_delay = $urandom_range(1, 4);
      sel = $urandom_range(0, 9);
      r = (sel < 6) || (sel == 9);
      w = (sel >= 6);
      a = ADDR_W'(($urandom_range(0, 3) * LINES) + $urandom_range(0, LINES - 1));
      d = $urandom;
      model_access(w, a, d, hit, exp);
      if (!w) exp_q.push_back(exp);
      r0 = mem_reads;
      w0 = mem_writes;
      do_access(r, w, a, d, 1'b1, rd, lat, sreq, sst, to);
      want_lat = (!w && hit) ? 2 : 3 + ack_delay;
      checks++;
      if (to !== 1'b0 || lat !== want_lat) begin
        errors++; $display("FAIL rand_latency n=%0d addr=%h lat=%0d want=%0d timeout=%b", n, a, lat, want_lat, to);
      end
      checks++;
      if (mem_reads - r0 !== ((!w && !hit) ? 1 : 0) || mem_writes - w0 !== (w ? 1 : 0)) begin
        errors++; $display("FAIL rand_memops n=%0d addr=%h reads=%0d writes=%0d hit=%b store=%b", n, a, mem_reads - r0, mem_writes - w0, hit, w);
      end
      if (!w) begin
        want = exp_q.pop_front();
        checks++;
        if (rd !== want) begin
          errors++; $display("FAIL rand_rdata n=%0d addr=%h got=%h want=%h", n, a, rd, want);
        end
      end
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mem_image differing words=%0d want=0", bad); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    cpu_r_en   = 1'b0;
    cpu_w_en   = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    auto_mem   = 1'b1;
    ack_delay  = 2;
    mem_reads  = 0;
    mem_writes = 0;
    last_addr  = '0;
    last_we    = 1'b0;
    last_wdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i] = $urandom;
      dut_mem[i] = ref_mem[i];
    end
    model_flush();
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_load();
    test_index_conflict();
    test_reset_mid_read();
    test_write_priority();
    test_random();
    test_mem_image();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends with a report.
  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter ADDR_W, default 12, word address width shared with the CPU data port.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter INDEX_W, default 4, giving 2^INDEX_W direct-mapped one-word lines; tag width = ADDR_W-INDEX_W.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cpu_r_en / cpu_w_en  in  1 each  active-high CPU load/store request, held until cpu_ready.
REQ-007 cpu_addr  in  ADDR_W  word address; cpu_wdata  in  DATA_W  store data.
REQ-008 cpu_rdata  out  DATA_W  load result, valid in the cpu_ready cycle.
REQ-009 cpu_ready  out  1  one-cycle completion pulse; stall  out  1  high whenever state != IDLE.
REQ-010 mem_req, mem_we  out  1  main-memory request / write qualifier; mem_addr out ADDR_W; mem_wdata out DATA_W.
REQ-011 mem_rdata  in  DATA_W; mem_ack  in  1  one-cycle memory completion pulse.

Function
REQ-012 FSM states IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESP; all outputs registered.
REQ-013 IDLE: on cpu_r_en or cpu_w_en, latch addr/wdata/op, go LOOKUP; both high = store (write priority).
REQ-014 LOOKUP, load hit (valid and tag match): cpu_rdata <= line data, go RESP; read-hit latency = request cycle + 2 (cpu_ready pulses in RESP).
REQ-015 LOOKUP, load miss: go MEM_READ with mem_req=1, mem_we=0, mem_addr=latched address.
REQ-016 MEM_READ: hold mem_req until mem_ack; on ack fill line (data, tag, valid=1), cpu_rdata <= mem_rdata, drop mem_req, go RESP.
REQ-017 LOOKUP, store: write-through, no-write-allocate; on hit update line data; always go MEM_WRITE with mem_req=1, mem_we=1, mem_wdata=latched data.
REQ-018 MEM_WRITE: hold until mem_ack, then drop mem_req, go RESP; store miss leaves array unchanged.
REQ-019 RESP: cpu_ready=1 for exactly one cycle, go IDLE; a new request is sampled no earlier than the next IDLE cycle.
REQ-020 mem_ack outside MEM_READ/MEM_WRITE is ignored; CPU request changes while stall=1 are ignored (latched copy used).
REQ-021 Index wrap: addresses differing only in tag map to same line; miss evicts silently (write-through, no dirty state).

Reset
REQ-022 rst low: state=IDLE, all valid bits 0, mem_req=0, mem_we=0, cpu_ready=0, stall=0, cpu_rdata=0, mem_addr=0, mem_wdata=0, immediately and independent of clk.
REQ-023 Reset mid-transaction abandons it; no cpu_ready issued; late mem_ack after reset is ignored.

Configuration
REQ-024 Macro CACHE_STATS_EN: when defined, adds outputs hit_cnt, miss_cnt (32 bits each, saturating, incremented once per LOOKUP, cleared by reset); when undefined, ports and counters are absent and timing is identical.

Structure
REQ-025 Package cache_pkg holds the state enum, ADDR_W/DATA_W/INDEX_W defaults and tag-width helper constant.
REQ-026 One sub-module cache_array: valid/tag/data storage with combinational read by index and synchronous write; valid clear on rst.

Verification
REQ-027 After reset, load 0x010 with mem_rdata=0xDEADBEEF, ack 3 cycles later -> one mem read, cpu_rdata=0xDEADBEEF with cpu_ready.
REQ-028 Repeat load 0x010 -> no mem_req, cpu_ready 2 cycles after request, data 0xDEADBEEF.
REQ-029 Store 0x010=0x12345678 then load 0x010 -> mem write with mem_we=1, subsequent load hits returning 0x12345678.
REQ-030 Load 0x110 (same index, tag differs) then 0x010 -> both miss, two mem reads.
REQ-031 Assert rst low during MEM_READ -> mem_req drops same cycle, no cpu_ready, next load 0x010 misses.
REQ-032 cpu_r_en and cpu_w_en both high at 0x020 -> treated as store, mem_we=1.
